mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal values 8..64, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  request a new operation.
REQ-005 SHALL have port op_i  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-006 SHALL have port opdata1_i  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port opdata2_i  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port hilo_i  input  2*WIDTH  accumulator value {HI,LO} for MADD/MSUB ops.
REQ-009 SHALL have port annul_i  input  1  abort the operation in flight (exception/flush).
REQ-010 SHALL have port result_o  output  2*WIDTH  {HI,LO} result.
REQ-011 SHALL have port ready_o  output  1  one-cycle pulse: result_o is valid.
REQ-012 SHALL have port busy_o  output  1  operation in flight; high in every state except IDLE.
REQ-013 SHALL have port div_by_zero_o  output  1  qualifies ready_o: the completed op was DIV/DIVU with divisor 0.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC, FIXUP and DONE.
REQ-015 In IDLE with start_i=1 and annul_i=0, SHALL latch op_i, opdata1_i, opdata2_i and hilo_i, and SHALL go to CALC (or to DONE on divide-by-zero).
REQ-016 SHALL ignore start_i in every state other than IDLE, and SHALL leave the latched operands unchanged.
REQ-017 SHALL stay in CALC for exactly WIDTH cycles, processing one bit per cycle (shift-add multiply, restoring divide on magnitudes), counted by a down-counter of $clog2(WIDTH)+1 bits.
REQ-018 In FIXUP (1 cycle), SHALL apply sign correction and accumulation and then enter DONE.
REQ-019 In DONE (1 cycle), SHALL assert ready_o and update result_o, then return to IDLE.
REQ-020 For a normal op, ready_o SHALL be high in cycle WIDTH+2, counting the start-sampled cycle as cycle 0.
REQ-021 For DIV/DIVU with opdata2_i=0, ready_o SHALL be high in cycle 1 with div_by_zero_o=1, HI=dividend and LO=all ones.
REQ-022 Signed ops SHALL take operand magnitudes (two's-complement negate when the MSB is 1); the product and quotient SHALL be negated when the operand signs differ.
REQ-023 The signed-op remainder SHALL take the sign of the dividend.
REQ-024 For DIV with most-negative / -1, SHALL give LO=2^(WIDTH-1) bit pattern and HI=0, with no flag.
REQ-025 Multiply results SHALL be full 2*WIDTH; divide results SHALL be HI=remainder, LO=quotient.
REQ-026 MADD/MADDU SHALL produce hilo_i + product, and MSUB/MSUBU SHALL produce hilo_i - product, both modulo 2^(2*WIDTH) with no overflow flag.
REQ-027 annul_i=1 in any non-IDLE state SHALL return the FSM to IDLE at the next edge with no ready_o pulse and result_o unchanged.
REQ-028 annul_i=1 in IDLE SHALL suppress a coincident start_i.
REQ-029 result_o SHALL hold the last completed result until the next DONE.
REQ-030 div_by_zero_o SHALL be 0 whenever ready_o is 0.
REQ-031 Back-to-back operation: a start_i presented in the cycle after DONE (IDLE) SHALL be accepted.

Reset
REQ-032 rst=0 SHALL immediately force the FSM to IDLE and the counter to 0.
REQ-033 rst=0 SHALL clear result_o, ready_o, busy_o and div_by_zero_o to 0, and SHALL clear all latched operands.
REQ-034 Reset asserted mid-operation SHALL discard the operation; no ready_o pulse SHALL follow reset release.
REQ-035 The first start_i SHALL be accepted in the first clock edge after reset deassertion.

Configuration
REQ-036 Macro MULT_DIV_UNIT_ACC_EN, when defined, SHALL compile in the hilo_i latch and the FIXUP adder/subtractor; MADD/MADDU/MSUB/MSUBU SHALL behave per REQ-026.
REQ-037 When MULT_DIV_UNIT_ACC_EN is undefined, hilo_i SHALL be unused and codes 100/110 SHALL execute as MULT and 101/111 as MULTU, with identical latency.

Verification
REQ-038 SHALL cover (WIDTH=32): MULT 0xFFFFFFFE x 0x00000003 -> ready_o in cycle 34, result_o=0xFFFFFFFF_FFFFFFFA, busy_o high for cycles 1-33.
REQ-039 SHALL cover: DIV 0xFFFFFFF9 / 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD; DIVU same operands -> HI=0x00000001, LO=0x7FFFFFFC.
REQ-040 SHALL cover: DIVU 0x00000005 / 0 -> ready_o in cycle 1, div_by_zero_o=1, result_o=0x00000005_FFFFFFFF.
REQ-041 SHALL cover: MSUB hilo_i=0x0000000A, 2 x 3 -> result_o=0x00000000_00000004 with ACC_EN defined; result_o=0x00000000_00000006 with it undefined.
REQ-042 SHALL cover: annul_i pulse in cycle 10 of a DIVU -> busy_o low from cycle 11, no ready_o, result_o unchanged; a new MULTU 7 x 9 started in cycle 11 -> result_o=63.
REQ-043 SHALL cover: rst=0 in cycle 15 of a MULT -> all outputs 0 immediately, no ready_o after release, start_i accepted on the first edge after release.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one bit per cycle, then sign fixup.
// MULT_DIV_UNIT_ACC_EN enables the hilo_i accumulate/subtract path.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic               dbz_q;
  logic [2*WIDTH-1:0] result_q;

  logic               in_signed, in_div, in_dbz, accept;
  logic [WIDTH-1:0]   in_a_mag;

  assign in_signed = ~op_i[0];
  assign in_div    = (op_i[2:1] == 2'b01);
  assign in_dbz    = in_div && (opdata2_i == '0);
  assign in_a_mag  = (in_signed && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign accept    = (state_q == IDLE) && start_i && !annul_i;

  logic             sgn_q, div_q, a_neg, b_neg, res_neg;
  logic [WIDTH-1:0] b_mag;

  assign sgn_q   = ~op_q[0];
  assign div_q   = (op_q[2:1] == 2'b01);
  assign a_neg   = sgn_q & a_q[WIDTH-1];
  assign b_neg   = sgn_q & b_q[WIDTH-1];
  assign res_neg = a_neg ^ b_neg;
  assign b_mag   = b_neg ? -b_q : b_q;

  // lo_q holds |opdata1| for both kinds: multiplier bits (product is
  // commutative) or dividend bits shifted into the partial remainder.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
    hi_step   = mul_sum[WIDTH:1];
    lo_step   = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      if (!div_diff[WIDTH+1]) begin
        hi_step = div_diff[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_shift[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s, mul_res, fix_res;
  logic [WIDTH-1:0]   quo, rem;

`ifdef MULT_DIV_UNIT_ACC_EN
  logic [2*WIDTH-1:0] hilo_q;
`else
  logic unused_hilo;
  assign unused_hilo = ^hilo_i;
`endif

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = res_neg ? -prod : prod;
    quo     = res_neg ? -lo_q : lo_q;
    rem     = a_neg ? -hi_q : hi_q;
    mul_res = prod_s;
`ifdef MULT_DIV_UNIT_ACC_EN
    if (op_q[2]) begin
      mul_res = op_q[1] ? (hilo_q - prod_s) : (hilo_q + prod_s);
    end
`endif
    fix_res = div_q ? {rem, quo} : mul_res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy_o        = (state_q != IDLE);
    ready_o       = (state_q == DONE);
    div_by_zero_o = (state_q == DONE) && dbz_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_dbz ? DONE : CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && annul_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      dbz_q    <= 1'b0;
      result_q <= '0;
`ifdef MULT_DIV_UNIT_ACC_EN
      hilo_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= op_i;
            a_q   <= opdata1_i;
            b_q   <= opdata2_i;
            hi_q  <= '0;
            lo_q  <= in_a_mag;
            dbz_q <= in_dbz;
`ifdef MULT_DIV_UNIT_ACC_EN
            hilo_q <= hilo_i;
`endif
            if (in_dbz) begin
              cnt_q    <= '0;
              result_q <= {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              cnt_q <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          if (annul_i) begin
            cnt_q <= '0;
          end else begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIXUP: begin
          if (!annul_i) begin
            result_q <= fix_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (WIDTH=32); expectations come from
// native SV arithmetic, honouring MULT_DIV_UNIT_ACC_EN when defined.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic [2:0]     op_i = '0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic [2*W-1:0] hilo_i = '0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;
  logic           div_by_zero_o;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .opdata1_i     (opdata1_i),
    .opdata2_i     (opdata2_i),
    .hilo_i        (hilo_i),
    .annul_i       (annul_i),
    .result_o      (result_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res = '0;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] hilo);
    exp_t        e;
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e.dbz = 1'b0;
    e.lat = W + 2;
    if (op[2:1] == 2'b01) begin
      if (b == 32'd0) begin
        e.res = {a, 32'hFFFF_FFFF};
        e.dbz = 1'b1;
        e.lat = 1;
      end else if (!op[0]) begin
        sq = sa / sb;
        sr = sa % sb;
        e.res = {sr[31:0], sq[31:0]};
      end else begin
        uq = ua / ub;
        ur = ua % ub;
        e.res = {ur[31:0], uq[31:0]};
      end
    end else begin
      if (!op[0]) p = 64'(sa * sb);
      else        p = ua * ub;
      e.res = p;
`ifdef MULT_DIV_UNIT_ACC_EN
      if (op[2]) e.res = op[1] ? (hilo - p) : (hilo + p);
`else
      if (op[2] && hilo === 64'hx) e.res = p;
`endif
    end
    return e;
  endfunction

  // Drives start for one cycle at the current negedge; returns at cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hilo, input bit push);
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    hilo_i    = hilo;
    if (push) exp_q.push_back(model(op, a, b, hilo));
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, input string name);
    int   cyc;
    bit   busy_ok, dbz_ok;
    exp_t e;
    cyc = cyc0;
    busy_ok = 1'b1;
    dbz_ok  = 1'b1;
    while (ready_o !== 1'b1 && cyc < 200) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (div_by_zero_o !== 1'b0) dbz_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got ready with no expectation queued", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL %s latency: got cycle %0d expected %0d", name, cyc, e.lat);
      end
      checks++;
      if (result_o !== e.res) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", name, result_o, e.res);
      end
      checks++;
      if (div_by_zero_o !== e.dbz) begin
        errors++;
        $display("FAIL %s dbz: got %b expected %b", name, div_by_zero_o, e.dbz);
      end
      last_res = e.res;
    end
    checks++;
    if (!busy_ok || !dbz_ok) begin
      errors++;
      $display("FAIL %s pending: busy_ok %b dbz_ok %b expected 1 1", name, busy_ok, dbz_ok);
    end
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: ready %b busy %b expected 0 0", name, ready_o, busy_o);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({result_o, ready_o, busy_o, div_by_zero_o} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h %b %b %b expected 0 0 0 0",
               result_o, ready_o, busy_o, div_by_zero_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult();
    issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, '0, 1'b1);
    wait_done(1, "mult_neg");
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 1'b1);
    wait_done(1, "multu_max");
    issue(3'b000, 32'h8000_0000, 32'h8000_0000, '0, 1'b1);
    wait_done(1, "mult_minmin");
    issue(3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFF9, '0, 1'b1);
    wait_done(1, "mult_negneg");
  endtask

  task automatic test_div();
    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, '0, 1'b1);
    wait_done(1, "div_neg");
    issue(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, '0, 1'b1);
    wait_done(1, "divu");
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b1);
    wait_done(1, "div_minneg1");
    issue(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, '0, 1'b1);
    wait_done(1, "div_negdivisor");
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 1'b1);
    wait_done(1, "divu_equal");
  endtask

  task automatic test_div_by_zero();
    issue(3'b011, 32'h0000_0005, 32'h0000_0000, '0, 1'b1);
    wait_done(1, "divu_zero");
    issue(3'b010, 32'hFFFF_FFFD, 32'h0000_0000, '0, 1'b1);
    wait_done(1, "div_zero");
  endtask

  task automatic test_acc();
    issue(3'b110, 32'd2, 32'd3, 64'h0000_0000_0000_000A, 1'b1);
    wait_done(1, "msub");
    issue(3'b100, 32'hFFFF_FFFF, 32'd5, 64'h1234_5678_0000_0001, 1'b1);
    wait_done(1, "madd");
    issue(3'b101, 32'hFFFF_FFFF, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(1, "maddu_wrap");
    issue(3'b111, 32'd3, 32'd4, 64'd5, 1'b1);
    wait_done(1, "msubu_wrap");
  endtask

  task automatic test_annul();
    bit rdy_bad;
    rdy_bad = 1'b0;
    issue(3'b011, 32'd1000, 32'd7, '0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (ready_o !== 1'b0) rdy_bad = 1'b1;
      if (c == 10) annul_i = 1'b1;
      @(negedge clk);
    end
    annul_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || rdy_bad) begin
      errors++;
      $display("FAIL annul state: busy %b ready %b early_ready %b expected 0 0 0",
               busy_o, ready_o, rdy_bad);
    end
    checks++;
    if (result_o !== last_res) begin
      errors++;
      $display("FAIL annul hold: got %h expected %h", result_o, last_res);
    end
    issue(3'b001, 32'd7, 32'd9, '0, 1'b1);
    wait_done(1, "multu_after_annul");
  endtask

  task automatic test_ignore_start();
    issue(3'b001, 32'd5, 32'd6, '0, 1'b1);
    repeat (4) @(negedge clk);
    start_i   = 1'b1;
    op_i      = 3'b011;
    opdata1_i = 32'd100;
    opdata2_i = 32'd0;
    hilo_i    = 64'hFFFF;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(6, "ignore_start");
  endtask

  task automatic test_rst_midop();
    issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, '0, 1'b0);
    repeat (14) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({result_o, ready_o, busy_o, div_by_zero_o} !== '0) begin
      errors++;
      $display("FAIL midop_reset outputs: got %h %b %b %b expected 0 0 0 0",
               result_o, ready_o, busy_o, div_by_zero_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(3'b001, 32'd11, 32'd13, '0, 1'b1);
    wait_done(1, "first_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] h;
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i == 2) ? 32'd0 : $urandom;
      h  = {$urandom, $urandom};
      issue(op, a, b, h, 1'b1);
      wait_done(1, "back_to_back");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_acc();
    test_annul();
    test_ignore_start();
    test_rst_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
